// File: rtl/sdq_pkg.sv
// Shared types for the store drain queue: store-size encodings, the queued entry
// record, and helpers for byte counts and lane masks.
package sdq_pkg;

  localparam int SDQ_ADDR_W = 32;
  localparam int SDQ_DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } sz_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [SDQ_ADDR_W-1:0] addr;
    logic [SDQ_DATA_W-1:0] data;
    sz_e                   typ;
  } entry_t;

  // Reserved size reports zero bytes so it can never overlap anything.
  function automatic logic [2:0] size_bytes(input logic [1:0] t);
    case (t)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [SDQ_DATA_W-1:0] lane_mask(input logic [2:0] n);
    case (n)
      3'd1:    return SDQ_DATA_W'(32'h0000_00FF);
      3'd2:    return SDQ_DATA_W'(32'h0000_FFFF);
      3'd4:    return SDQ_DATA_W'(32'hFFFF_FFFF);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/sdq_fifo.sv
// Circular entry storage for the store drain queue; exposes every slot in age
// order (index 0 = head) so the top level can scan it for forwarding.
module sdq_fifo
  import sdq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  entry_t                       entry_i,
  output entry_t [DEPTH-1:0]           ord_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    head_d  = pop_i  ? head_q + PW'(1) : head_q;
    tail_d  = push_i ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[tail_q] <= entry_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ord_o[i] = mem_q[head_q + PW'(i)];
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/store_drain_queue.sv
// Commit-side store buffer: queues committed stores, drains them to memory over
// a req/ack handshake, and forwards (or stalls) overlapping load lookups.
module store_drain_queue
  import sdq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         writeRequest,
  input  logic [ADDR_W-1:0]            writeAddress,
  input  logic [DATA_W-1:0]            writeData,
  input  logic [1:0]                   writeType,
  output logic                         writeAccept,
  output logic                         memReq,
  output logic [ADDR_W-1:0]            memAddr,
  output logic [DATA_W-1:0]            memData,
  output logic [1:0]                   memType,
  input  logic                         memAck,
  input  logic [ADDR_W-1:0]            loadAddr,
  input  logic [1:0]                   loadType,
  output logic                         fwdHit,
  output logic [DATA_W-1:0]            fwdData,
  output logic                         loadStall,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         errFlag
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int XW = SDQ_ADDR_W + 1;

  entry_t [DEPTH-1:0] ord;
  entry_t             wentry;
  logic [CW-1:0]      cnt;
  logic               full, legal, push, pop;

  drain_state_e       state_q, state_d;
  logic               req_q, req_d;
  entry_t             head_q, head_d;
  logic               err_q, err_d;

  always_comb begin
    case (writeType)
      SZ_BYTE: legal = 1'b1;
      SZ_HALF: legal = ~writeAddress[0];
      SZ_WORD: legal = (writeAddress[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  assign writeAccept = ~full;
  assign push        = writeRequest & writeAccept & legal;
  assign wentry      = '{addr: SDQ_ADDR_W'(writeAddress),
                         data: SDQ_DATA_W'(writeData),
                         typ:  sz_e'(writeType)};

  sdq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .entry_i (wentry),
    .ord_o   (ord),
    .count_o (cnt),
    .full_o  (full),
    .empty_o (empty)
  );

  // Drain FSM: the head stays queued (and forwardable) until its ack pops it.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    head_d  = head_q;
    pop     = 1'b0;
    err_d   = err_q | (writeRequest & writeAccept & ~legal);
    case (state_q)
      ST_IDLE: begin
        if (cnt != '0) begin
          head_d  = ord[0];
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (memAck) begin
          pop = 1'b1;
          if (cnt > CW'(1)) begin
            head_d = ord[1];
          end else if (push) begin
            head_d = wentry;
          end else begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      head_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      head_q  <= head_d;
      err_q   <= err_d;
    end
  end

  assign memReq  = req_q;
  assign memAddr = ADDR_W'(head_q.addr);
  assign memData = DATA_W'(head_q.data);
  assign memType = head_q.typ;
  assign count   = cnt;
  assign errFlag = err_q;

  logic [2:0]            ls, es;
  logic [XW-1:0]         la, la_end, ea, ea_end;
  logic [1:0]            off;
  logic                  hit_c, stall_c;
  logic [SDQ_DATA_W-1:0] fwd_c;

  // Oldest-to-youngest scan so the youngest overlapping entry has the last word.
  always_comb begin
    hit_c   = 1'b0;
    stall_c = 1'b0;
    fwd_c   = '0;
    off     = '0;
    ls      = size_bytes(loadType);
    la      = {1'b0, SDQ_ADDR_W'(loadAddr)};
    la_end  = la + XW'(ls);
    es      = '0;
    ea      = '0;
    ea_end  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt) begin
        es     = size_bytes(ord[i].typ);
        ea     = {1'b0, ord[i].addr};
        ea_end = ea + XW'(es);
        if ((ls != '0) && (es != '0) && (ea < la_end) && (la < ea_end)) begin
          if ((ea <= la) && (la_end <= ea_end)) begin
            hit_c   = 1'b1;
            stall_c = 1'b0;
            off     = la[1:0] - ea[1:0];
            fwd_c   = (ord[i].data >> {off, 3'b000}) & lane_mask(ls);
          end else begin
            hit_c   = 1'b0;
            stall_c = 1'b1;
            fwd_c   = '0;
          end
        end
      end
    end
  end

  assign fwdHit    = hit_c;
  assign loadStall = stall_c;
  assign fwdData   = DATA_W'(fwd_c);

endmodule

// File: tb/tb_store_drain_queue.sv
// Directed bench for store_drain_queue: drain handshake, full queue, forwarding,
// partial-overlap stall, illegal-store drop and mid-handshake reset.
module tb_store_drain_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        writeRequest = 1'b0;
  logic [31:0] writeAddress = '0;
  logic [31:0] writeData = '0;
  logic [1:0]  writeType = '0;
  logic        writeAccept;
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic [1:0]  memType;
  logic        memAck = 1'b0;
  logic [31:0] loadAddr = '0;
  logic [1:0]  loadType = '0;
  logic        fwdHit;
  logic [31:0] fwdData;
  logic        loadStall;
  logic        empty;
  logic [2:0]  count;
  logic        errFlag;

  int checks = 0;
  int errors = 0;

  store_drain_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .writeRequest (writeRequest),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .writeType    (writeType),
    .writeAccept  (writeAccept),
    .memReq       (memReq),
    .memAddr      (memAddr),
    .memData      (memData),
    .memType      (memType),
    .memAck       (memAck),
    .loadAddr     (loadAddr),
    .loadType     (loadType),
    .fwdHit       (fwdHit),
    .fwdData      (fwdData),
    .loadStall    (loadStall),
    .empty        (empty),
    .count        (count),
    .errFlag      (errFlag)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    writeRequest = 1'b1;
    writeAddress = a;
    writeData    = d;
    writeType    = t;
  endtask

  task automatic lookup(input logic [31:0] a, input logic [1:0] t);
    loadAddr = a;
    loadType = t;
    #1;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_memData", memData, 32'd0);
    chk("rst_memType", 32'(memType), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_accept", 32'(writeAccept), 32'd1);
    chk("rst_err", 32'(errFlag), 32'd0);

    // Single word store and handshake
    store(32'h1000, 32'hDEADBEEF, 2'b10);
    tick();
    writeRequest = 1'b0;
    chk("sw_count", 32'(count), 32'd1);
    chk("sw_req_early", 32'(memReq), 32'd0);
    lookup(32'h1000, 2'b10);
    chk("sw_fwd_hit", 32'(fwdHit), 32'd1);
    chk("sw_fwd_data", fwdData, 32'hDEADBEEF);
    tick();
    chk("sw_req", 32'(memReq), 32'd1);
    chk("sw_addr", memAddr, 32'h1000);
    chk("sw_data", memData, 32'hDEADBEEF);
    chk("sw_type", 32'(memType), 32'd2);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    chk("sw_req_done", 32'(memReq), 32'd0);
    chk("sw_empty", 32'(empty), 32'd1);

    // Full queue: four taken, fifth refused, then back-to-back drain
    for (int i = 0; i < 4; i++) begin
      store(32'h100 + 32'(4 * i), 32'(i + 1), 2'b10);
      tick();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_accept", 32'(writeAccept), 32'd0);
    store(32'h110, 32'd5, 2'b10);
    tick();
    writeRequest = 1'b0;
    chk("full_fifth_dropped", 32'(count), 32'd4);
    chk("full_head_addr", memAddr, 32'h100);
    chk("full_head_req", 32'(memReq), 32'd1);
    memAck = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("drain_addr", memAddr, 32'h100 + 32'(4 * i));
      chk("drain_data", memData, 32'(i + 1));
      chk("drain_req", 32'(memReq), 32'd1);
    end
    tick();
    memAck = 1'b0;
    chk("drain_done_req", 32'(memReq), 32'd0);
    chk("drain_done_empty", 32'(empty), 32'd1);

    // Forwarding: youngest of two overlapping words wins
    store(32'h2000, 32'h11223344, 2'b10);
    tick();
    store(32'h2000, 32'hAABBCCDD, 2'b10);
    tick();
    writeRequest = 1'b0;
    lookup(32'h2001, 2'b00);
    chk("fwd_byte_hit", 32'(fwdHit), 32'd1);
    chk("fwd_byte_data", fwdData, 32'h000000CC);
    chk("fwd_byte_stall", 32'(loadStall), 32'd0);
    lookup(32'h2002, 2'b01);
    chk("fwd_half_data", fwdData, 32'h0000AABB);
    lookup(32'h2004, 2'b10);
    chk("fwd_miss_hit", 32'(fwdHit), 32'd0);
    chk("fwd_miss_data", fwdData, 32'd0);
    memAck = 1'b1;
    tick();
    tick();
    memAck = 1'b0;
    chk("fwd_drained", 32'(count), 32'd0);

    // Partial overlap stalls; ack while idle is ignored
    store(32'h3002, 32'h55, 2'b00);
    tick();
    writeRequest = 1'b0;
    lookup(32'h3000, 2'b10);
    chk("part_stall", 32'(loadStall), 32'd1);
    chk("part_hit", 32'(fwdHit), 32'd0);
    lookup(32'h3002, 2'b00);
    chk("part_byte_data", fwdData, 32'h55);
    memAck = 1'b1;
    tick();
    chk("idle_ack_ignored", 32'(count), 32'd1);
    tick();
    memAck = 1'b0;
    chk("part_drained", 32'(count), 32'd0);

    // Illegal half store at odd address
    store(32'h4001, 32'h1234, 2'b01);
    tick();
    writeRequest = 1'b0;
    chk("ill_count", 32'(count), 32'd0);
    chk("ill_err", 32'(errFlag), 32'd1);
    tick();
    chk("ill_err_sticky", 32'(errFlag), 32'd1);
    chk("ill_no_req", 32'(memReq), 32'd0);

    // Reset in the middle of a handshake
    for (int i = 0; i < 3; i++) begin
      store(32'h5000 + 32'(4 * i), 32'(i), 2'b10);
      tick();
    end
    writeRequest = 1'b0;
    chk("mid_req", 32'(memReq), 32'd1);
    chk("mid_count", 32'(count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_req", 32'(memReq), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_accept", 32'(writeAccept), 32'd1);
    chk("mid_rst_err", 32'(errFlag), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
